// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between the two write requesters, the pop consumer and the FIFO
// pointer/arbiter block. The storage array itself lives outside the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int AW = 5
);
  logic          push_a;
  logic [31:0]   data_a;
  logic          ready_a;
  logic          push_b;
  logic [31:0]   data_b;
  logic          ready_b;
  logic          pop;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  modport slave (
    input  push_a, data_a, push_b, data_b, pop,
    output ready_a, ready_b, wr_en, wr_addr, wr_data,
           rd_addr, rd_valid, count, full, empty
  );

  modport master (
    output push_a, data_a, push_b, data_b, pop,
    input  ready_a, ready_b, wr_en, wr_addr, wr_data,
           rd_addr, rd_valid, count, full, empty
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Two-port write arbiter and pointer/occupancy tracker for a 32x32 FIFO.
// Define FIFO_ARB_FIXED_PRIO_EN to make A always win contention (default round-robin).
module fifo_wr_arbiter #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clock,
  input  logic             reset,
  fifo_wr_arbiter_if.slave bus
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_valid_q, rd_valid_d;

  logic full;
  logic empty;
  logic grant_a;
  logic grant_b;
  logic grant;
  logic pop_ok;

  // Flags come from the registered count, so a pop never frees space in its own cycle.
  assign full  = (count_q == DEPTH_W);
  assign empty = (count_q == '0);

`ifdef FIFO_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (reset && !full) begin
      grant_a = bus.push_a;
      grant_b = bus.push_b && !bus.push_a;
    end
  end
`else
  typedef enum logic {GRANT_A, GRANT_B} grant_t;
  grant_t last_grant_q, last_grant_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_grant_q <= GRANT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    last_grant_d = last_grant_q;
    if (reset && !full) begin
      if (bus.push_a && bus.push_b) begin
        if (last_grant_q == GRANT_B) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
      end else begin
        grant_a = bus.push_a;
        grant_b = bus.push_b;
      end
    end
    if (grant_a) begin
      last_grant_d = GRANT_A;
    end else if (grant_b) begin
      last_grant_d = GRANT_B;
    end
  end
`endif

  assign grant  = grant_a || grant_b;
  assign pop_ok = bus.pop && !empty;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    wr_en_d    = grant;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_addr_d  = rd_addr_q;
    rd_valid_d = pop_ok;

    if (grant) begin
      wr_addr_d = wptr_q;
      wr_data_d = grant_a ? bus.data_a : bus.data_b;
      wptr_d    = wptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_addr_d = rptr_q;
      rptr_d    = rptr_q + 1'b1;
    end

    case ({grant, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_addr_q  <= rd_addr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.ready_a  = grant_a;
  assign bus.ready_b  = grant_b;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.count    = count_q;
  assign bus.full     = full;
  assign bus.empty    = empty;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed plus random stimulus for fifo_wr_arbiter with a write/read scoreboard
// and a small reference model of pointers, occupancy and arbitration.
module tb_fifo_wr_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fifo_wr_arbiter_if bus ();

  fifo_wr_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_cnt    = 0;
  int          m_wptr   = 0;
  int          m_rptr   = 0;
  bit          m_last_b = 1'b1;
  logic [31:0] m_wa     = '0;
  logic [31:0] m_wd     = '0;
  logic [31:0] m_ra     = '0;

  logic [36:0] wq[$];
  logic [4:0]  rq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic rst_n, input logic pa, input logic [31:0] da,
                       input logic pb, input logic [31:0] db, input logic pp);
    logic ga, gb, pv, exp_wr;
    logic [36:0] w;
    reset       = rst_n;
    bus.push_a  = pa;
    bus.data_a  = da;
    bus.push_b  = pb;
    bus.data_b  = db;
    bus.pop     = pp;
    #1;
    ga = 1'b0;
    gb = 1'b0;
    if (rst_n && m_cnt != 32) begin
      if (pa && pb) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
        ga = 1'b1;
`else
        if (m_last_b) ga = 1'b1;
        else          gb = 1'b1;
`endif
      end else begin
        ga = pa;
        gb = pb;
      end
    end
    chk("ready_a", {31'b0, bus.ready_a}, {31'b0, ga});
    chk("ready_b", {31'b0, bus.ready_b}, {31'b0, gb});
    pv     = rst_n && pp && (m_cnt != 0);
    exp_wr = ga || gb;
    if (!rst_n) begin
      m_cnt = 0; m_wptr = 0; m_rptr = 0; m_last_b = 1'b1;
      m_wa = '0; m_wd = '0; m_ra = '0;
      wq.delete();
      rq.delete();
    end else begin
      if (exp_wr) begin
        wq.push_back({5'(m_wptr), (ga ? da : db)});
        m_wptr   = (m_wptr + 1) % 32;
        m_last_b = gb;
        m_cnt++;
      end
      if (pv) begin
        rq.push_back(5'(m_rptr));
        m_rptr = (m_rptr + 1) % 32;
        m_cnt--;
      end
    end
    @(posedge clock);
    #1;
    chk("wr_en", {31'b0, bus.wr_en}, {31'b0, exp_wr});
    if (exp_wr && wq.size() > 0) begin
      w    = wq.pop_front();
      m_wa = {27'b0, w[36:32]};
      m_wd = w[31:0];
    end
    chk("wr_addr", {27'b0, bus.wr_addr}, m_wa);
    chk("wr_data", bus.wr_data, m_wd);
    chk("rd_valid", {31'b0, bus.rd_valid}, {31'b0, pv});
    if (pv && rq.size() > 0) m_ra = {27'b0, rq.pop_front()};
    chk("rd_addr", {27'b0, bus.rd_addr}, m_ra);
    chk("count", {26'b0, bus.count}, 32'(m_cnt));
    chk("full",  {31'b0, bus.full},  {31'b0, (m_cnt == 32)});
    chk("empty", {31'b0, bus.empty}, {31'b0, (m_cnt == 0)});
    $display("cycle rst_n=%0b pa=%0b pb=%0b pop=%0b -> wr_en=%0b wr_addr=%0d wr_data=%08h rd_valid=%0b rd_addr=%0d count=%0d",
             rst_n, pa, pb, pp, bus.wr_en, bus.wr_addr, bus.wr_data, bus.rd_valid, bus.rd_addr, bus.count);
  endtask

  initial begin
    bus.push_a = 1'b0; bus.data_a = '0;
    bus.push_b = 1'b0; bus.data_b = '0;
    bus.pop    = 1'b0;

    // Reset state, with requests present to show they are never granted
    cycle(1'b0, 1'b1, 32'hDEAD0001, 1'b1, 32'hDEAD0002, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Single push on A
    cycle(1'b1, 1'b1, 32'h11111111, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Contention after reset: A,B,A,B (or A x4 with fixed priority)
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b1, 32'hA0000000 + i, 1'b1, 32'hB0000000 + i, 1'b0);

    // Fill through B, then a refused 33rd push
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 32; i++)
      cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'hC0DE0000 + i, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'hC0DE0020, 1'b0);

    // Full: pop and push together refuses the push; next push lands at 0
    cycle(1'b1, 1'b1, 32'h5A5A5A5A, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h5A5A5A5B, 1'b0, 32'h0, 1'b0);

    // Empty pop ignored; then push+pop at count=1 holds count
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h00000E01, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h00000E02, 1'b0, 32'h0, 1'b1);

    // Reset at count=10 with a pending push
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 1'b1, 32'h10000000 + i, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h1000000A, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Random traffic with occasional resets
    for (int i = 0; i < 300; i++)
      cycle(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)), $urandom(),
            1'($urandom_range(0, 1)), $urandom(), ($urandom_range(0, 2) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
